// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds the FSM state encoding, the default bus widths and the word-alignment mask.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mau_timeout_cnt.sv
// Timeout counter for the memory access unit.
// Clear has priority over enable. The expire output is asserted while the count equals TIMEOUT-1.
module mau_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller.
// Issues one req/ack bus transaction per load or store, stalls the pipeline until it finishes, and times out stuck accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e state;

  logic req_any;
  logic valid;
  logic expire;

  assign req_any = MemRead_i | MemWrite_i;
  assign valid   = (MemRead_i ^ MemWrite_i) && ((addr_i[1:0] & ALIGN_MASK) == 2'b00);

  mau_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (state == ST_IDLE),
    .en     ((state == ST_WAIT) && !mem_ack_i),
    .expire (expire)
  );

  // Stall rises in the same cycle a valid request appears so EX_MEM holds it.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      case (state)
        ST_IDLE: stall_o = valid;
        ST_WAIT: stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            state       <= ST_WAIT;
          end else if (req_any) begin
            err_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              rdata_o <= mem_rdata_i;
            end
            state <= ST_DONE;
          end else if (expire) begin
            mem_req_o <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a short timeout.
// Drives the bus side by hand and checks stall, error, bus and load-data outputs cycle by cycle.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Each cycle: inputs change 2ns after the rising edge, outputs are sampled 1ns later.
  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    repeat (2) next_cycle();
    #1;
    check("rst_req",   32'(mem_req_o), 32'd0);
    check("rst_we",    32'(mem_we_o),  32'd0);
    check("rst_addr",  mem_addr_o,     32'd0);
    check("rst_wdata", mem_wdata_o,    32'd0);
    check("rst_rdata", rdata_o,        32'd0);
    check("rst_err",   32'(err_o),     32'd0);
    check("rst_stall", 32'(stall_o),   32'd0);
    rst_i = 1'b0;

    // Load 0x100, acked on the first WAIT cycle.
    next_cycle();
    MemRead_i = 1'b1;
    addr_i    = 32'h100;
    #1;
    check("t1_idle_stall", 32'(stall_o),   32'd1);
    check("t1_idle_req",   32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t1_wait_req",   32'(mem_req_o), 32'd1);
    check("t1_wait_we",    32'(mem_we_o),  32'd0);
    check("t1_wait_addr",  mem_addr_o,     32'h100);
    check("t1_wait_stall", 32'(stall_o),   32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    next_cycle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    MemRead_i   = 1'b0;
    #1;
    check("t1_done_stall", 32'(stall_o),   32'd0);
    check("t1_done_rdata", rdata_o,        32'hDEADBEEF);
    check("t1_done_req",   32'(mem_req_o), 32'd0);
    check("t1_done_err",   32'(err_o),     32'd0);
    next_cycle();

    // Store 0x204, acked on the 4th WAIT cycle (coincides with the timeout cycle).
    MemWrite_i = 1'b1;
    addr_i     = 32'h204;
    wdata_i    = 32'h12345678;
    #1;
    check("t2_idle_stall", 32'(stall_o), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      #1;
      check($sformatf("t2_wait%0d_req", k),   32'(mem_req_o), 32'd1);
      check($sformatf("t2_wait%0d_stall", k), 32'(stall_o),   32'd1);
      check($sformatf("t2_wait%0d_we", k),    32'(mem_we_o),  32'd1);
      check($sformatf("t2_wait%0d_wdata", k), mem_wdata_o,    32'h12345678);
      check($sformatf("t2_wait%0d_addr", k),  mem_addr_o,     32'h204);
      if (k == 4) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
      end
    end
    next_cycle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    MemWrite_i  = 1'b0;
    wdata_i     = '0;
    #1;
    check("t2_done_stall", 32'(stall_o),   32'd0);
    check("t2_done_err",   32'(err_o),     32'd0);
    check("t2_done_rdata", rdata_o,        32'hDEADBEEF);
    check("t2_done_req",   32'(mem_req_o), 32'd0);
    next_cycle();

    // Misaligned load.
    MemRead_i = 1'b1;
    addr_i    = 32'h102;
    #1;
    check("t3a_stall", 32'(stall_o), 32'd0);
    next_cycle();
    MemRead_i = 1'b0;
    #1;
    check("t3a_err",   32'(err_o),     32'd1);
    check("t3a_req",   32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t3a_err_clr", 32'(err_o), 32'd0);

    // Load and store both requested.
    MemRead_i  = 1'b1;
    MemWrite_i = 1'b1;
    addr_i     = 32'h108;
    #1;
    check("t3b_stall", 32'(stall_o), 32'd0);
    next_cycle();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    #1;
    check("t3b_err", 32'(err_o),     32'd1);
    check("t3b_req", 32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t3b_err_clr", 32'(err_o), 32'd0);

    // Load 0x300 with no ack: aborted after 4 WAIT cycles.
    MemRead_i = 1'b1;
    addr_i    = 32'h300;
    #1;
    check("t4_idle_stall", 32'(stall_o), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      #1;
      check($sformatf("t4_wait%0d_req", k),   32'(mem_req_o), 32'd1);
      check($sformatf("t4_wait%0d_stall", k), 32'(stall_o),   32'd1);
      check($sformatf("t4_wait%0d_err", k),   32'(err_o),     32'd0);
    end
    next_cycle();
    MemRead_i = 1'b0;
    #1;
    check("t4_done_req",   32'(mem_req_o), 32'd0);
    check("t4_done_err",   32'(err_o),     32'd1);
    check("t4_done_rdata", rdata_o,        32'd0);
    check("t4_done_stall", 32'(stall_o),   32'd0);
    next_cycle();
    #1;
    check("t4_err_clr",    32'(err_o),   32'd0);
    check("t4_idle_stall", 32'(stall_o), 32'd0);

    // Back-to-back loads 0x10 and 0x14.
    MemRead_i = 1'b1;
    addr_i    = 32'h10;
    #1;
    check("t6a_idle_stall", 32'(stall_o), 32'd1);
    next_cycle();
    #1;
    check("t6a_wait_req",  32'(mem_req_o), 32'd1);
    check("t6a_wait_addr", mem_addr_o,     32'h10);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h11111111;
    next_cycle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    addr_i      = 32'h14;
    #1;
    check("t6a_done_stall", 32'(stall_o),   32'd0);
    check("t6a_done_rdata", rdata_o,        32'h11111111);
    check("t6a_done_req",   32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t6b_idle_stall", 32'(stall_o),   32'd1);
    check("t6b_idle_req",   32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t6b_wait_req",  32'(mem_req_o), 32'd1);
    check("t6b_wait_addr", mem_addr_o,     32'h14);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h22222222;
    next_cycle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    MemRead_i   = 1'b0;
    #1;
    check("t6b_done_rdata", rdata_o,        32'h22222222);
    check("t6b_done_req",   32'(mem_req_o), 32'd0);
    next_cycle();
    #1;
    check("t6_idle_req", 32'(mem_req_o), 32'd0);

    // Reset during the 2nd WAIT cycle of a load, then a stray ack.
    MemRead_i = 1'b1;
    addr_i    = 32'h400;
    wdata_i   = 32'hAAAA0000;
    next_cycle();
    #1;
    check("t5_wait1_req", 32'(mem_req_o), 32'd1);
    next_cycle();
    rst_i = 1'b1;
    #1;
    check("t5_rst_stall", 32'(stall_o), 32'd0);
    next_cycle();
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    wdata_i   = '0;
    #1;
    check("t5_req",   32'(mem_req_o), 32'd0);
    check("t5_we",    32'(mem_we_o),  32'd0);
    check("t5_addr",  mem_addr_o,     32'd0);
    check("t5_wdata", mem_wdata_o,    32'd0);
    check("t5_rdata", rdata_o,        32'd0);
    check("t5_err",   32'(err_o),     32'd0);
    check("t5_stall", 32'(stall_o),   32'd0);
    next_cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55555555;
    next_cycle();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    #1;
    check("t5_ack_rdata", rdata_o,        32'd0);
    check("t5_ack_req",   32'(mem_req_o), 32'd0);
    check("t5_ack_stall", 32'(stall_o),   32'd0);
    check("t5_ack_err",   32'(err_o),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
